// File: rtl/classify_arbiter_pkg.sv
// Shared types and constants for the classification-engine arbiter.
// Imported by the top level and by the round-robin selector.
package classify_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int PIXEL_BITS             = 4;
    localparam int COUNT_BITS             = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/classify_arbiter_rr_arbiter.sv
// Round-robin selector: first asserted request at or after i_rr_ptr, wrapping.
// Purely combinational; the caller registers the result and advances the pointer.
module rr_arbiter
    import classify_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/classify_arbiter.sv
// Shares one classification engine among NUM_REQ requesters: round-robin grant,
// vector latch, start/wait/response sequencing with timeout, result statistics.
module classify_arbiter
    import classify_arbiter_pkg::*;
#(
    parameter int VECTOR_SIZE    = 64,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ*VECTOR_SIZE*PIXEL_BITS-1:0] req_vector,
    output logic [NUM_REQ-1:0]                      grant,
    output logic                                    cls_start,
    output logic [VECTOR_SIZE*PIXEL_BITS-1:0]       cls_vector,
    input  logic                                    cls_result,
    input  logic                                    cls_done,
    output logic                                    rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]              rsp_id,
    output logic                                    rsp_result,
    output logic                                    rsp_error,
    output logic                                    busy,
    output logic [COUNT_BITS-1:0]                   total_count,
    output logic [COUNT_BITS-1:0]                   diseased_count
);

    localparam int VECTOR_BITS = VECTOR_SIZE * PIXEL_BITS;
    localparam int IDX_W       = $clog2(NUM_REQ);
    localparam int WCNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                  r_state, w_state_nx;
    logic [IDX_W-1:0]        r_rr_ptr, w_rr_ptr_nx;
    logic [IDX_W-1:0]        r_gnt_id, w_gnt_id_nx;
    logic [WCNT_W-1:0]       r_wait_cnt, w_wait_cnt_nx;
    logic [NUM_REQ-1:0]      r_grant, w_grant_nx;
    logic                    r_cls_start, w_cls_start_nx;
    logic [VECTOR_BITS-1:0]  r_cls_vector, w_cls_vector_nx;
    logic                    r_rsp_valid, w_rsp_valid_nx;
    logic [IDX_W-1:0]        r_rsp_id, w_rsp_id_nx;
    logic                    r_rsp_result, w_rsp_result_nx;
    logic                    r_rsp_error, w_rsp_error_nx;
    logic                    r_busy, w_busy_nx;
    logic [COUNT_BITS-1:0]   r_total_count, w_total_count_nx;
    logic [COUNT_BITS-1:0]   r_diseased_count, w_diseased_count_nx;

    logic [NUM_REQ-1:0]      w_arb_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_arb_grant),
        .o_idx    (w_arb_idx)
    );

    assign w_timeout = (r_wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx          = r_state;
        w_rr_ptr_nx         = r_rr_ptr;
        w_gnt_id_nx         = r_gnt_id;
        w_wait_cnt_nx       = r_wait_cnt;
        w_grant_nx          = '0;
        w_cls_start_nx      = 1'b0;
        w_cls_vector_nx     = r_cls_vector;
        w_rsp_valid_nx      = 1'b0;
        w_rsp_id_nx         = r_rsp_id;
        w_rsp_result_nx     = r_rsp_result;
        w_rsp_error_nx      = r_rsp_error;
        w_total_count_nx    = r_total_count;
        w_diseased_count_nx = r_diseased_count;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_cls_vector_nx = req_vector[int'(w_arb_idx)*VECTOR_BITS +: VECTOR_BITS];
                    w_grant_nx      = w_arb_grant;
                    w_cls_start_nx  = 1'b1;
                    w_gnt_id_nx     = w_arb_idx;
                    w_rr_ptr_nx     = (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                         : w_arb_idx + IDX_W'(1);
                    w_state_nx      = ST_START;
                end
            end
            ST_START: begin
                w_wait_cnt_nx = '0;
                w_state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the timeout cycle still counts as a real result.
                if (cls_done) begin
                    w_rsp_valid_nx  = 1'b1;
                    w_rsp_id_nx     = r_gnt_id;
                    w_rsp_result_nx = cls_result;
                    w_rsp_error_nx  = 1'b0;
                    w_state_nx      = ST_RESP;
                end else if (w_timeout) begin
                    w_rsp_valid_nx  = 1'b1;
                    w_rsp_id_nx     = r_gnt_id;
                    w_rsp_result_nx = 1'b0;
                    w_rsp_error_nx  = 1'b1;
                    w_state_nx      = ST_RESP;
                end else begin
                    w_wait_cnt_nx = r_wait_cnt + WCNT_W'(1);
                end
            end
            ST_RESP: begin
                if (!r_rsp_error) begin
                    if (r_total_count != '1) begin
                        w_total_count_nx = r_total_count + COUNT_BITS'(1);
                    end
                    if (r_rsp_result && (r_diseased_count != '1)) begin
                        w_diseased_count_nx = r_diseased_count + COUNT_BITS'(1);
                    end
                end
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr         <= '0;
            r_gnt_id         <= '0;
            r_wait_cnt       <= '0;
            r_grant          <= '0;
            r_cls_start      <= 1'b0;
            r_cls_vector     <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_id         <= '0;
            r_rsp_result     <= 1'b0;
            r_rsp_error      <= 1'b0;
            r_busy           <= 1'b0;
            r_total_count    <= '0;
            r_diseased_count <= '0;
        end else begin
            r_rr_ptr         <= w_rr_ptr_nx;
            r_gnt_id         <= w_gnt_id_nx;
            r_wait_cnt       <= w_wait_cnt_nx;
            r_grant          <= w_grant_nx;
            r_cls_start      <= w_cls_start_nx;
            r_cls_vector     <= w_cls_vector_nx;
            r_rsp_valid      <= w_rsp_valid_nx;
            r_rsp_id         <= w_rsp_id_nx;
            r_rsp_result     <= w_rsp_result_nx;
            r_rsp_error      <= w_rsp_error_nx;
            r_busy           <= w_busy_nx;
            r_total_count    <= w_total_count_nx;
            r_diseased_count <= w_diseased_count_nx;
        end
    end

    assign grant          = r_grant;
    assign cls_start      = r_cls_start;
    assign cls_vector     = r_cls_vector;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_result     = r_rsp_result;
    assign rsp_error      = r_rsp_error;
    assign busy           = r_busy;
    assign total_count    = r_total_count;
    assign diseased_count = r_diseased_count;

endmodule

// File: tb/tb_classify_arbiter.sv
// Directed bench for classify_arbiter (4 requesters, 64-pixel vectors, 16-cycle timeout).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_classify_arbiter;

    localparam int NR  = 4;
    localparam int VB  = 64 * 4;
    localparam int TMO = 16;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req;
    logic [NR*VB-1:0]   req_vector;
    logic [NR-1:0]      grant;
    logic               cls_start;
    logic [VB-1:0]      cls_vector;
    logic               cls_result;
    logic               cls_done;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic               rsp_result;
    logic               rsp_error;
    logic               busy;
    logic [15:0]        total_count;
    logic [15:0]        diseased_count;

    int n_checks = 0;
    int n_pass   = 0;

    classify_arbiter #(
        .VECTOR_SIZE    (64),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_vector     (req_vector),
        .grant          (grant),
        .cls_start      (cls_start),
        .cls_vector     (cls_vector),
        .cls_result     (cls_result),
        .cls_done       (cls_done),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .rsp_error      (rsp_error),
        .busy           (busy),
        .total_count    (total_count),
        .diseased_count (diseased_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VB-1:0] act, input logic [VB-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One job from IDLE; done_at < 0 means the engine never answers.
    task automatic job(input logic [NR-1:0] pat, input logic [NR-1:0] exp_gnt, input int exp_id,
                       input int done_at, input logic res);
        req = pat;
        tick(1);
        chk("grant", grant, exp_gnt);
        chk("cls_start", cls_start, 1);
        chk("busy_start", busy, 1);
        req        = '0;
        req_vector = ~req_vector;
        tick(1);
        chk("grant_pulse", grant, 0);
        chk("start_pulse", cls_start, 0);
        if (done_at >= 0) begin
            tick(done_at);
            cls_done   = 1'b1;
            cls_result = res;
            tick(1);
            cls_done   = 1'b0;
            cls_result = 1'b0;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_error", rsp_error, 0);
            chk("rsp_result", rsp_result, res);
        end else begin
            tick(TMO - 1);
            chk("no_early_rsp", rsp_valid, 0);
            tick(1);
            chk("tmo_rsp_valid", rsp_valid, 1);
            chk("tmo_rsp_error", rsp_error, 1);
            chk("tmo_rsp_result", rsp_result, 0);
        end
        chk("rsp_id", rsp_id, exp_id);
        tick(1);
        chk("rsp_pulse", rsp_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    logic [VB-1:0] v_a;
    logic [NR-1:0] g_seen [5];
    int            g_cyc  [5];
    int            seen;
    logic [NR-1:0] exp_order [5];

    initial begin
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        rst_n      = 1'b0;
        req        = '0;
        req_vector = '0;
        cls_done   = 1'b0;
        cls_result = 1'b0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_total", total_count, 0);
        chk("rst_vector", cls_vector, 0);
        rst_n = 1'b1;
        tick(1);

        // single request with a distinctive vector
        v_a = {4{64'hDEAD_BEEF_0123_4567}} ^ {VB{1'b0}};
        v_a[7:0] = 8'h5A;
        req_vector = '0;
        req_vector[2*VB +: VB] = v_a;
        job(4'b0100, 4'b0100, 2, 9, 1'b1);
        chk("vector_latched", cls_vector, v_a);
        chk("single_total", total_count, 1);
        chk("single_dis", diseased_count, 1);

        // timeout; pointer sits at 3 so requester 0 wins after wrap
        job(4'b0001, 4'b0001, 0, -1, 1'b0);
        chk("tmo_total", total_count, 1);
        chk("tmo_dis", diseased_count, 1);

        // done on the timeout cycle beats the timeout
        job(4'b0010, 4'b0010, 1, TMO - 1, 1'b0);
        chk("coll_total", total_count, 2);
        chk("coll_dis", diseased_count, 1);

        // done while idle is ignored
        cls_done   = 1'b1;
        cls_result = 1'b1;
        tick(3);
        chk("idle_done_rsp", rsp_valid, 0);
        chk("idle_done_busy", busy, 0);
        cls_done   = 1'b0;
        cls_result = 1'b0;
        tick(1);
        chk("idle_done_total", total_count, 2);

        // reset while waiting on the engine
        req = 4'b1000;
        tick(1);
        chk("mid_grant", grant, 4'b1000);
        req = '0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_total", total_count, 0);
        chk("mid_rst_dis", diseased_count, 0);
        chk("mid_rst_vector", cls_vector, 0);
        chk("mid_rst_flags", {rsp_valid, rsp_error, rsp_result, cls_start, rsp_id}, 0);
        tick(2);
        rst_n    = 1'b1;
        cls_done = 1'b1;
        tick(1);
        cls_done = 1'b0;
        chk("late_done_rsp", rsp_valid, 0);
        tick(2);
        chk("late_done_rsp2", rsp_valid, 0);
        chk("late_done_busy", busy, 0);

        // fairness with all requesters held and an instant engine
        req      = 4'b1111;
        cls_done = 1'b1;
        seen     = 0;
        for (int c = 0; c < 40 && seen < 5; c++) begin
            tick(1);
            if (grant != '0) begin
                g_seen[seen] = grant;
                g_cyc[seen]  = c;
                seen++;
                if (seen == 5) req = '0;
            end
        end
        chk("fair_count", seen, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen) chk($sformatf("fair_order%0d", i), g_seen[i], exp_order[i]);
            if (i > 0 && i < seen) chk($sformatf("fair_space%0d", i), g_cyc[i] - g_cyc[i-1], 4);
        end
        for (int c = 0; c < 20 && busy; c++) tick(1);
        cls_done = 1'b0;
        tick(1);
        chk("fair_drained", busy, 0);
        chk("fair_total", total_count, 5);
        chk("fair_dis", diseased_count, 0);

        // saturation from a preloaded near-full count
        force dut.r_total_count    = 16'hFFFE;
        force dut.r_diseased_count = 16'hFFFE;
        #1;
        release dut.r_total_count;
        release dut.r_diseased_count;
        tick(1);
        chk("preload_total", total_count, 16'hFFFE);
        job(4'b0001, 4'b0001, 0, 0, 1'b1);
        chk("sat1_total", total_count, 16'hFFFF);
        chk("sat1_dis", diseased_count, 16'hFFFF);
        job(4'b0001, 4'b0001, 0, 0, 1'b1);
        job(4'b0001, 4'b0001, 0, 0, 1'b1);
        chk("sat3_total", total_count, 16'hFFFF);
        chk("sat3_dis", diseased_count, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
